// File: rtl/iter_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Optional early termination is enabled by defining ITER_MULT_EARLY_TERM_EN.
package iter_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/iter_mult_abs.sv
// Conditional two's-complement negate: res = neg ? -val : val.
// Used for operand magnitudes and for restoring the product sign.
module iter_mult_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (-val_i) : val_i;

endmodule

// File: rtl/iter_mult.sv
// Radix-2 shift-add multiplier, one partial product per cycle, signed or unsigned.
// Defining ITER_MULT_EARLY_TERM_EN leaves RUN as soon as the remaining multiplier is zero.
// Handshake: a transfer happens on a rising edge where valid && ready; in_ready is high
// only in IDLE, out_valid only in DONE, so input and output transfers never coincide.
module iter_mult
  import iter_mult_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Prod
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_fix, addend;

  // Magnitudes are unsigned WIDTH-bit, so the most-negative operand maps onto 2^(W-1).
  iter_mult_abs #(.W(WIDTH)) u_abs_a (
    .val_i (A),
    .neg_i (signed_mode & A[WIDTH-1]),
    .res_o (a_mag)
  );

  iter_mult_abs #(.W(WIDTH)) u_abs_b (
    .val_i (B),
    .neg_i (signed_mode & B[WIDTH-1]),
    .res_o (b_mag)
  );

  iter_mult_abs #(.W(2*WIDTH)) u_abs_p (
    .val_i (acc_q),
    .neg_i (neg_q),
    .res_o (acc_fix)
  );

  assign addend    = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign Prod      = prod_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d  = RUN;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + addend;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
`ifdef ITER_MULT_EARLY_TERM_EN
        if ((cnt_q == LAST) || (mplier_d == '0)) state_d = FIX;
`else
        if (cnt_q == LAST) state_d = FIX;
`endif
      end
      FIX: begin
        prod_d  = acc_fix;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_iter_mult.sv
// Self-checking bench for iter_mult: a WIDTH=64 and a WIDTH=8 instance share clock and reset.
module tb_iter_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         v64, rdy64, sm64, ov64, or64;
  logic [63:0]  a64, b64;
  logic [127:0] p64;
  logic         v8, rdy8, sm8, ov8, or8;
  logic [7:0]   a8, b8;
  logic [15:0]  p8;

  logic [127:0] exp_q64[$];
  logic [15:0]  exp_q8[$];
  int n_checks = 0;
  int n_fail   = 0;

  iter_mult #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .signed_mode(sm64),
    .A(a64), .B(b64), .out_valid(ov64), .out_ready(or64), .Prod(p64)
  );

  iter_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .signed_mode(sm8),
    .A(a8), .B(b8), .out_valid(ov8), .out_ready(or8), .Prod(p8)
  );

  function automatic logic [127:0] model64(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic signed [127:0] sa, sb;
    if (s) begin sa = $signed(a); sb = $signed(b); end
    else begin sa = {64'b0, a}; sb = {64'b0, b}; end
    return sa * sb;
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    if (s) begin sa = $signed(a); sb = $signed(b); end
    else begin sa = {8'b0, a}; sb = {8'b0, b}; end
    return sa * sb;
  endfunction

  // Edges from the accepting edge until out_valid is seen high.
  function automatic int exp_lat(input int width, input logic [63:0] b, input logic s);
    logic [63:0] mask, m;
    int hi;
    mask = (64'd1 << width) - 64'd1;
    m = (s && b[width-1]) ? ((~b + 64'd1) & mask) : b;
    hi = -1;
    for (int i = 0; i < width; i++) if (m[i]) hi = i;
`ifdef ITER_MULT_EARLY_TERM_EN
    return (hi < 0) ? 2 : 2 + hi;
`else
    return width + 1;
`endif
  endfunction

  // ---------------- 64-bit driver tasks ----------------
  task automatic start64(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input string name, output int lat);
    @(negedge clk);
    n_checks++;
    if (rdy64 !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready: got %b want 1", name, rdy64); end
    a64 = a; b64 = b; sm64 = s; v64 = 1'b1;
    exp_q64.push_back(model64(a, b, s));
    lat = exp_lat(64, b, s);
    @(posedge clk); #1 v64 = 1'b0;
  endtask

  task automatic wait64(input string name, input int lat);
    int edges;
    logic [127:0] exp;
    edges = 0;
    while (ov64 !== 1'b1 && edges < 300) begin @(posedge clk); #1; edges++; end
    n_checks++;
    if (edges != lat) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, edges, lat); end
    exp = (exp_q64.size() > 0) ? exp_q64.pop_front() : 128'hx;
    n_checks++;
    if (p64 !== exp) begin n_fail++; $display("FAIL %s_prod: got %h want %h", name, p64, exp); end
  endtask

  task automatic release64(input string name);
    or64 = 1'b1;
    @(posedge clk); #1 or64 = 1'b0;
    n_checks++;
    if (ov64 !== 1'b0) begin n_fail++; $display("FAIL %s_valid_drop: got %b want 0", name, ov64); end
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic s, input string name);
    int lat;
    start64(a, b, s, name, lat);
    wait64(name, lat);
    release64(name);
  endtask

  // ---------------- 8-bit driver tasks ----------------
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input string name, output int lat);
    @(negedge clk);
    n_checks++;
    if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready: got %b want 1", name, rdy8); end
    a8 = a; b8 = b; sm8 = s; v8 = 1'b1;
    exp_q8.push_back(model8(a, b, s));
    lat = exp_lat(8, {56'b0, b}, s);
    @(posedge clk); #1 v8 = 1'b0;
  endtask

  task automatic wait8(input string name, input int lat);
    int edges;
    logic [15:0] exp;
    edges = 0;
    while (ov8 !== 1'b1 && edges < 300) begin @(posedge clk); #1; edges++; end
    n_checks++;
    if (edges != lat) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, edges, lat); end
    exp = (exp_q8.size() > 0) ? exp_q8.pop_front() : 16'hx;
    n_checks++;
    if (p8 !== exp) begin n_fail++; $display("FAIL %s_prod: got %h want %h", name, p8, exp); end
  endtask

  task automatic release8(input string name);
    or8 = 1'b1;
    @(posedge clk); #1 or8 = 1'b0;
    n_checks++;
    if (ov8 !== 1'b0) begin n_fail++; $display("FAIL %s_valid_drop: got %b want 0", name, ov8); end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input string name);
    int lat;
    start8(a, b, s, name, lat);
    wait8(name, lat);
    release8(name);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_checks += 6;
    if (rdy64 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready64: got %b want 0", rdy64); end
    if (ov64 !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid64: got %b want 0", ov64); end
    if (p64 !== '0)     begin n_fail++; $display("FAIL rst_prod64: got %h want 0", p64); end
    if (rdy8 !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready8: got %b want 0", rdy8); end
    if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid8: got %b want 0", ov8); end
    if (p8 !== '0)      begin n_fail++; $display("FAIL rst_prod8: got %h want 0", p8); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks += 2;
    if (rdy64 !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready64: got %b want 1", rdy64); end
    if (rdy8 !== 1'b1)  begin n_fail++; $display("FAIL rel_in_ready8: got %b want 1", rdy8); end
  endtask

  task automatic test_mult64;
    op64(64'd3000, 64'd55000, 1'b0, "u64_3000x55000");
    op64('1, 64'd5, 1'b1, "s64_m1x5");
    op64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, "s64_minsq");
  endtask

  task automatic test_mult8;
    op8(8'hF9, 8'h05, 1'b1, "s8_m7x5");
    op8(8'hF9, 8'h05, 1'b0, "u8_249x5");
    op8(8'h80, 8'h80, 1'b1, "s8_minsq");
    op8(8'hFF, 8'hFF, 1'b0, "u8_maxsq");
    op8(8'h55, 8'h00, 1'b1, "s8_bzero");
    op8(8'h00, 8'h80, 1'b1, "s8_azero_negb");
  endtask

  task automatic test_random8;
    for (int i = 0; i < 6; i++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand8");
  endtask

  task automatic test_backpressure;
    int lat;
    logic [15:0] held;
    held = model8(8'h12, 8'h34, 1'b0);
    start8(8'h12, 8'h34, 1'b0, "bp_first", lat);
    wait8("bp_first", lat);
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h04; sm8 = 1'b0; v8 = 1'b1; or8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks += 3;
      if (ov8 !== 1'b1)  begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", ov8); end
      if (p8 !== held)   begin n_fail++; $display("FAIL bp_hold_prod: got %h want %h", p8, held); end
      if (rdy8 !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready: got %b want 0", rdy8); end
    end
    exp_q8.push_back(model8(8'h03, 8'h04, 1'b0));
    or8 = 1'b1;
    @(posedge clk); #1 or8 = 1'b0;
    n_checks += 2;
    if (ov8 !== 1'b0)  begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", ov8); end
    if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", rdy8); end
    @(posedge clk); #1 v8 = 1'b0;
    wait8("bp_second", exp_lat(8, 64'd4, 1'b0));
    release8("bp_second");
  endtask

  task automatic test_early_term;
    op64(64'd10, 64'h20, 1'b0, "et64_10x32");
    op64(64'd7, 64'd0, 1'b0, "et64_bzero");
  endtask

  task automatic test_reset_mid_run;
    int lat;
    start64(64'd3000, '1, 1'b0, "mid_rst", lat);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks += 3;
    if (ov64 !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", ov64); end
    if (p64 !== '0)     begin n_fail++; $display("FAIL mid_rst_prod: got %h want 0", p64); end
    if (rdy64 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b want 0", rdy64); end
    exp_q64.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (rdy64 !== 1'b1) begin n_fail++; $display("FAIL mid_rst_release_ready: got %b want 1", rdy64); end
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (ov64 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_valid: got %b want 0", ov64); end
    end
    op64(64'd2, 64'd8, 1'b0, "post_rst_2x8");
  endtask

  initial begin
    rst = 1'b1;
    v64 = 1'b0; sm64 = 1'b0; or64 = 1'b0; a64 = '0; b64 = '0;
    v8  = 1'b0; sm8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0;
    test_reset;
    test_mult64;
    test_mult8;
    test_random8;
    test_backpressure;
    test_early_term;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
